// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 mouse definitions: host command bytes, device reply bytes,
// device IDs, the init-controller state type and the init command table.
// ----------------------------------------------------------------------------
package ps2_pkg;

  // Host -> device commands
  localparam logic [7:0] PS2_CMD_RESET_CMD       = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_STREAM_MODE = 8'hEA;
  localparam logic [7:0] PS2_CMD_ENABLE_DATA_REP = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_SAMPLE_RATE = 8'hF3;
  localparam logic [7:0] PS2_CMD_GET_DEVICE_ID   = 8'hF2;

  // Device -> host replies
  localparam logic [7:0] PS2_RD_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RD_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RD_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_RD_BAT_FAIL = 8'hFC;

  // Device IDs
  localparam logic [7:0] PS2_ID_STD   = 8'h00;
  localparam logic [7:0] PS2_ID_WHEEL = 8'h03;

  // Magic sample-rate knock that unlocks the IntelliMouse wheel
  localparam logic [7:0] PS2_PROBE_RATE_1 = 8'hC8;
  localparam logic [7:0] PS2_PROBE_RATE_2 = 8'h64;
  localparam logic [7:0] PS2_PROBE_RATE_3 = 8'h50;

  // Positions in the full (wheel-enabled) command table
  localparam logic [3:0] TBL_RESET  = 4'd0;
  localparam logic [3:0] TBL_DEVID  = 4'd7;
  localparam logic [3:0] TBL_SKIP   = 4'd7;   // entries skipped without wheel probe

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID0,
    ST_WAIT_DEVID,
    ST_STREAM,
    ST_ERROR
  } ctrl_state_t;

  // Full init table; the non-wheel sequence is entry 0 followed by 8..11.
  function automatic logic [7:0] cmd_lookup(input logic [3:0] idx,
                                            input logic [7:0] rate);
    case (idx)
      4'd0:    cmd_lookup = PS2_CMD_RESET_CMD;
      4'd1:    cmd_lookup = PS2_CMD_SET_SAMPLE_RATE;
      4'd2:    cmd_lookup = PS2_PROBE_RATE_1;
      4'd3:    cmd_lookup = PS2_CMD_SET_SAMPLE_RATE;
      4'd4:    cmd_lookup = PS2_PROBE_RATE_2;
      4'd5:    cmd_lookup = PS2_CMD_SET_SAMPLE_RATE;
      4'd6:    cmd_lookup = PS2_PROBE_RATE_3;
      4'd7:    cmd_lookup = PS2_CMD_GET_DEVICE_ID;
      4'd8:    cmd_lookup = PS2_CMD_SET_SAMPLE_RATE;
      4'd9:    cmd_lookup = rate;
      4'd10:   cmd_lookup = PS2_CMD_SET_STREAM_MODE;
      default: cmd_lookup = PS2_CMD_ENABLE_DATA_REP;
    endcase
  endfunction

endpackage

// File: rtl/mouse_stream_ctrl_pkt_asm.sv
// ----------------------------------------------------------------------------
// mouse_pkt_asm
// Assembles 3- or 4-byte PS/2 mouse packets in stream mode. Drops byte-1
// candidates without the always-one bit 3, and discards a partial packet when
// the inter-byte gap times out.
//   clk, rst_n      clock, async active-low reset
//   enable          stream phase active; idx held at 0 otherwise
//   wheel_mode      1 = 4-byte packets, 0 = 3-byte packets
//   timeout         inter-byte gap limit reached this cycle
//   rx_valid/data   received byte pulse
//   pkt_valid       one-cycle pulse, pkt_byte_1..4 just updated
//   sync_err        one-cycle pulse, byte dropped or partial packet discarded
// ----------------------------------------------------------------------------
module mouse_pkt_asm
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wheel_mode,
  input  logic       timeout,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       pkt_valid,
  output logic [7:0] pkt_byte_1,
  output logic [7:0] pkt_byte_2,
  output logic [7:0] pkt_byte_3,
  output logic [7:0] pkt_byte_4,
  output logic       sync_err
);

  logic [1:0] idx;
  logic [7:0] buf_0, buf_1, buf_2;
  logic       flush;
  logic [1:0] cur_idx;
  logic [1:0] last_idx;

  // A timeout on a partial packet wins over a same-cycle byte, which is then
  // treated as a fresh byte 1.
  assign flush    = enable && timeout && (idx != 2'd0);
  assign cur_idx  = flush ? 2'd0 : idx;
  assign last_idx = wheel_mode ? 2'd3 : 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      buf_0      <= '0;
      buf_1      <= '0;
      buf_2      <= '0;
      pkt_valid  <= 1'b0;
      pkt_byte_1 <= '0;
      pkt_byte_2 <= '0;
      pkt_byte_3 <= '0;
      pkt_byte_4 <= '0;
      sync_err   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (!enable) begin
        idx <= '0;
      end else begin
        if (flush) begin
          idx      <= '0;
          sync_err <= 1'b1;
        end
        if (rx_valid) begin
          if (cur_idx == 2'd0 && !rx_data[3]) begin
            sync_err <= 1'b1;
          end else if (cur_idx == last_idx) begin
            idx        <= '0;
            pkt_valid  <= 1'b1;
            pkt_byte_1 <= buf_0;
            pkt_byte_2 <= buf_1;
            pkt_byte_3 <= wheel_mode ? buf_2 : rx_data;
            pkt_byte_4 <= wheel_mode ? rx_data : 8'h00;
          end else begin
            case (cur_idx)
              2'd0:    buf_0 <= rx_data;
              2'd1:    buf_1 <= rx_data;
              default: buf_2 <= rx_data;
            endcase
            idx <= cur_idx + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mouse_stream_ctrl.sv
// ----------------------------------------------------------------------------
// mouse_stream_ctrl
// PS/2 mouse init + stream controller. Walks a command table (reset, optional
// wheel probe, sample rate, stream mode, enable) with ACK/RESEND retries and
// timeouts, then hands received bytes to the packet assembler.
//   clk, rst_n         clock, async active-low reset
//   ps2_tx_ready       tx engine can accept a byte
//   ps2_rddata_valid   one-cycle pulse, ps2_rd_data valid
//   ps2_wr_stb/data    one-cycle write strobe; data held until next strobe
//   init_done          stream phase active
//   init_err           init failed, sticky until reset
//   wheel_mode         device reported ID 03, 4-byte packets
//   pkt_valid, pkt_byte_1..4, sync_err   packet assembler outputs
// ----------------------------------------------------------------------------
module mouse_stream_ctrl
  import ps2_pkg::*;
#(
  parameter bit          WHEEL_EN    = 1'b1,
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [23:0] ACK_TIMEOUT = 24'd100000,
  parameter logic [23:0] BAT_TIMEOUT = 24'd10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_tx_ready,
  input  logic       ps2_rddata_valid,
  input  logic [7:0] ps2_rd_data,
  output logic       ps2_wr_stb,
  output logic [7:0] ps2_wr_data,
  output logic       init_done,
  output logic       init_err,
  output logic       wheel_mode,
  output logic       pkt_valid,
  output logic [7:0] pkt_byte_1,
  output logic [7:0] pkt_byte_2,
  output logic [7:0] pkt_byte_3,
  output logic [7:0] pkt_byte_4,
  output logic       sync_err
);

  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [3:0] LAST_STEP = WHEEL_EN ? 4'd11 : 4'd4;

  ctrl_state_t        state;
  logic [3:0]         step;
  logic [RETRY_W-1:0] retry;
  logic [23:0]        timer;
  logic [23:0]        timer_inc;
  logic [3:0]         tbl_idx;
  logic               rx_ack;
  logic               retry_exhausted;

  // Without the wheel probe, step 1 onwards maps past the probe entries.
  assign tbl_idx         = (WHEEL_EN || step == 4'd0) ? step : step + TBL_SKIP;
  assign timer_inc       = (timer == '1) ? timer : timer + 24'd1;
  assign rx_ack          = ps2_rddata_valid && (ps2_rd_data == PS2_RD_ACK);
  assign retry_exhausted = (retry == RETRY_LAST);

  // NOTE: every register here uses non-blocking assignment; the defaults at
  // the top of the else branch are overridden by later assignments in the
  // case, so "last write wins" gives one-cycle strobes and timer clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      step        <= '0;
      retry       <= '0;
      timer       <= '0;
      ps2_wr_stb  <= 1'b0;
      ps2_wr_data <= '0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
      wheel_mode  <= 1'b0;
    end else begin
      ps2_wr_stb <= 1'b0;
      timer      <= timer_inc;
      case (state)
        ST_IDLE: begin
          if (ps2_tx_ready) begin
            state <= ST_SEND;
            timer <= '0;
          end
        end

        ST_SEND: begin
          if (ps2_tx_ready) begin
            ps2_wr_stb  <= 1'b1;
            ps2_wr_data <= cmd_lookup(tbl_idx, SAMPLE_RATE);
            timer       <= '0;
            state       <= ST_WAIT_ACK;
          end
        end

        ST_WAIT_ACK: begin
          if (rx_ack) begin
            timer <= '0;
            if (tbl_idx == TBL_RESET) begin
              state <= ST_WAIT_BAT;
            end else if (tbl_idx == TBL_DEVID) begin
              state <= ST_WAIT_DEVID;
            end else if (step == LAST_STEP) begin
              state     <= ST_STREAM;
              init_done <= 1'b1;
            end else begin
              step  <= step + 4'd1;
              retry <= '0;
              state <= ST_SEND;
            end
          end else if (ps2_rddata_valid || timer == ACK_TIMEOUT) begin
            // RESEND, garbage and silence are all treated as a failed attempt
            timer <= '0;
            if (retry_exhausted) begin
              state    <= ST_ERROR;
              init_err <= 1'b1;
            end else begin
              retry <= retry + 1'b1;
              state <= ST_SEND;
            end
          end
        end

        ST_WAIT_BAT: begin
          if (ps2_rddata_valid && ps2_rd_data == PS2_RD_BAT_OK) begin
            state <= ST_WAIT_ID0;
            timer <= '0;
          end else if ((ps2_rddata_valid && ps2_rd_data == PS2_RD_BAT_FAIL) ||
                       timer == BAT_TIMEOUT) begin
            state    <= ST_ERROR;
            init_err <= 1'b1;
            timer    <= '0;
          end
        end

        ST_WAIT_ID0: begin
          if (ps2_rddata_valid) begin
            step  <= step + 4'd1;
            retry <= '0;
            state <= ST_SEND;
            timer <= '0;
          end else if (timer == BAT_TIMEOUT) begin
            state    <= ST_ERROR;
            init_err <= 1'b1;
            timer    <= '0;
          end
        end

        ST_WAIT_DEVID: begin
          if (ps2_rddata_valid) begin
            wheel_mode <= (ps2_rd_data == PS2_ID_WHEEL);
            step       <= step + 4'd1;
            retry      <= '0;
            state      <= ST_SEND;
            timer      <= '0;
          end else if (timer == ACK_TIMEOUT) begin
            // Missing ID counts as another attempt at F2
            timer <= '0;
            if (retry_exhausted) begin
              state    <= ST_ERROR;
              init_err <= 1'b1;
            end else begin
              retry <= retry + 1'b1;
              state <= ST_SEND;
            end
          end
        end

        ST_STREAM: begin
          if (ps2_rddata_valid) timer <= '0;
        end

        ST_ERROR: ;

        default: state <= ST_IDLE;
      endcase
    end
  end

  mouse_pkt_asm u_pkt_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (init_done),
    .wheel_mode (wheel_mode),
    .timeout    ((state == ST_STREAM) && (timer == ACK_TIMEOUT)),
    .rx_valid   (ps2_rddata_valid),
    .rx_data    (ps2_rd_data),
    .pkt_valid  (pkt_valid),
    .pkt_byte_1 (pkt_byte_1),
    .pkt_byte_2 (pkt_byte_2),
    .pkt_byte_3 (pkt_byte_3),
    .pkt_byte_4 (pkt_byte_4),
    .sync_err   (sync_err)
  );

endmodule

// File: tb/tb_mouse_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mouse_stream_ctrl
// Directed bench with two controller instances: u_whl (WHEEL_EN=1) and u_std
// (WHEEL_EN=0). Only one is out of reset at a time; `sel` picks whose outputs
// are observed. The initial block plays the mouse: it waits for each command
// strobe, checks the byte and replies.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mouse_stream_ctrl;

  localparam logic [23:0] AT = 24'd40;
  localparam logic [23:0] BT = 24'd200;

  logic       clk = 1'b0;
  logic       rst_n_whl, rst_n_std;
  logic       tx_ready, rx_valid;
  logic [7:0] rx_data;
  logic       sel;

  logic       w_stb, w_done, w_err, w_wheel, w_pv, w_serr;
  logic [7:0] w_data, w_p1, w_p2, w_p3, w_p4;
  logic       s_stb, s_done, s_err, s_wheel, s_pv, s_serr;
  logic [7:0] s_data, s_p1, s_p2, s_p3, s_p4;

  logic       stb, done, err, wheel, pv, serr;
  logic [7:0] wdata, p1, p2, p3, p4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mouse_stream_ctrl #(.WHEEL_EN(1'b1), .SAMPLE_RATE(8'd100), .MAX_RETRY(3),
                      .ACK_TIMEOUT(AT), .BAT_TIMEOUT(BT)) u_whl (
    .clk(clk), .rst_n(rst_n_whl), .ps2_tx_ready(tx_ready),
    .ps2_rddata_valid(rx_valid), .ps2_rd_data(rx_data),
    .ps2_wr_stb(w_stb), .ps2_wr_data(w_data), .init_done(w_done),
    .init_err(w_err), .wheel_mode(w_wheel), .pkt_valid(w_pv),
    .pkt_byte_1(w_p1), .pkt_byte_2(w_p2), .pkt_byte_3(w_p3),
    .pkt_byte_4(w_p4), .sync_err(w_serr));

  mouse_stream_ctrl #(.WHEEL_EN(1'b0), .SAMPLE_RATE(8'd100), .MAX_RETRY(3),
                      .ACK_TIMEOUT(AT), .BAT_TIMEOUT(BT)) u_std (
    .clk(clk), .rst_n(rst_n_std), .ps2_tx_ready(tx_ready),
    .ps2_rddata_valid(rx_valid), .ps2_rd_data(rx_data),
    .ps2_wr_stb(s_stb), .ps2_wr_data(s_data), .init_done(s_done),
    .init_err(s_err), .wheel_mode(s_wheel), .pkt_valid(s_pv),
    .pkt_byte_1(s_p1), .pkt_byte_2(s_p2), .pkt_byte_3(s_p3),
    .pkt_byte_4(s_p4), .sync_err(s_serr));

  assign stb   = sel ? s_stb   : w_stb;
  assign wdata = sel ? s_data  : w_data;
  assign done  = sel ? s_done  : w_done;
  assign err   = sel ? s_err   : w_err;
  assign wheel = sel ? s_wheel : w_wheel;
  assign pv    = sel ? s_pv    : w_pv;
  assign serr  = sel ? s_serr  : w_serr;
  assign p1    = sel ? s_p1    : w_p1;
  assign p2    = sel ? s_p2    : w_p2;
  assign p3    = sel ? s_p3    : w_p3;
  assign p4    = sel ? s_p4    : w_p4;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rx pulse; called 1 ns after a rising edge.
  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Wait (bounded) for the next write strobe and check its byte.
  task automatic wait_tx(input logic [7:0] exp, input string tag,
                         output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      n++;
      if (stb) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_strobe_seen"}, {31'd0, found}, 32'd1);
    check(tag, {24'd0, wdata}, {24'd0, exp});
  endtask

  task automatic ack_cmd(input logic [7:0] exp, input string tag);
    int n;
    wait_tx(exp, tag, n);
    send_rx(8'hFA);
  endtask

  // Runaway guard
  initial begin
    #300000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, n2, seen_at, extra;
    logic seen;

    sel = 1'b1;
    rst_n_whl = 1'b0;
    rst_n_std = 1'b0;
    tx_ready  = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (3) tick();

    // ---------------- reset state ----------------
    check("rst_wr_stb", {31'd0, stb}, 32'd0);
    check("rst_wr_data", {24'd0, wdata}, 32'd0);
    check("rst_init_done", {31'd0, done}, 32'd0);
    check("rst_init_err", {31'd0, err}, 32'd0);
    check("rst_pkt_valid", {31'd0, pv}, 32'd0);

    // ---------------- 3-byte controller init, F4 RESEND x2 ----------------
    rst_n_std = 1'b1;
    wait_tx(8'hFF, "std_tx_ff", n0);
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    ack_cmd(8'hF3, "std_tx_f3");
    ack_cmd(8'h64, "std_tx_rate");
    ack_cmd(8'hEA, "std_tx_ea");
    wait_tx(8'hF4, "std_tx_f4_try1", n0);
    send_rx(8'hFE);
    wait_tx(8'hF4, "std_tx_f4_try2", n0);
    send_rx(8'hFE);
    check("std_not_done_before_ack", {31'd0, done}, 32'd0);
    wait_tx(8'hF4, "std_tx_f4_try3", n0);
    send_rx(8'hFA);
    tick();
    check("std_init_done", {31'd0, done}, 32'd1);
    check("std_init_err", {31'd0, err}, 32'd0);
    check("std_wheel_mode", {31'd0, wheel}, 32'd0);

    // ---------------- 3-byte packet ----------------
    send_rx(8'h09);
    send_rx(8'h10);
    check("std_no_early_pkt", {31'd0, pv}, 32'd0);
    send_rx(8'h20);
    check("std_pkt_valid", {31'd0, pv}, 32'd1);
    check("std_pkt_b1", {24'd0, p1}, 32'h09);
    check("std_pkt_b2", {24'd0, p2}, 32'h10);
    check("std_pkt_b3", {24'd0, p3}, 32'h20);
    check("std_pkt_b4", {24'd0, p4}, 32'h00);
    tick();
    check("std_pkt_valid_one_cycle", {31'd0, pv}, 32'd0);

    // ---------------- byte 1 without bit 3 ----------------
    send_rx(8'h00);
    check("std_sync_err_drop", {31'd0, serr}, 32'd1);
    check("std_drop_no_pkt", {31'd0, pv}, 32'd0);
    tick();
    check("std_sync_err_one_cycle", {31'd0, serr}, 32'd0);
    check("std_bytes_held", {24'd0, p1}, 32'h09);

    // ---------------- inter-byte timeout ----------------
    send_rx(8'h08);
    send_rx(8'h05);
    seen = 1'b0;
    seen_at = 0;
    for (int i = 1; i <= int'(AT) + 10; i++) begin
      tick();
      if (serr) begin
        seen = 1'b1;
        seen_at = i;
        break;
      end
    end
    check("std_timeout_sync_err", {31'd0, seen}, 32'd1);
    check("std_timeout_delay_ok",
          {31'd0, (seen_at >= int'(AT) && seen_at <= int'(AT) + 2)}, 32'd1);
    send_rx(8'h08);
    send_rx(8'h11);
    send_rx(8'h22);
    check("std_resync_pkt_valid", {31'd0, pv}, 32'd1);
    check("std_resync_b1", {24'd0, p1}, 32'h08);
    check("std_resync_b2", {24'd0, p2}, 32'h11);
    check("std_resync_b3", {24'd0, p3}, 32'h22);

    // ---------------- reset mid-packet ----------------
    send_rx(8'h08);
    #2;
    rst_n_std = 1'b0;
    #1;
    check("midrst_init_done", {31'd0, done}, 32'd0);
    check("midrst_pkt_b1", {24'd0, p1}, 32'h00);
    check("midrst_wr_data", {24'd0, wdata}, 32'h00);
    @(posedge clk);
    #1;
    rst_n_std = 1'b1;

    // ---------------- re-init, EA never acknowledged ----------------
    wait_tx(8'hFF, "std_reinit_ff", n0);
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    ack_cmd(8'hF3, "std_reinit_f3");
    ack_cmd(8'h64, "std_reinit_rate");
    wait_tx(8'hEA, "std_ea_try1", n0);
    wait_tx(8'hEA, "std_ea_try2", n1);
    check("std_ea_gap1",
          {31'd0, (n1 >= int'(AT) && n1 <= int'(AT) + 4)}, 32'd1);
    wait_tx(8'hEA, "std_ea_try3", n2);
    check("std_ea_gap2",
          {31'd0, (n2 >= int'(AT) && n2 <= int'(AT) + 4)}, 32'd1);
    extra = 0;
    for (int i = 0; i < int'(AT) + 8; i++) begin
      tick();
      if (stb) extra++;
    end
    check("std_no_fourth_ea", extra, 32'd0);
    check("std_init_err_set", {31'd0, err}, 32'd1);
    check("std_init_done_clear", {31'd0, done}, 32'd0);

    // ---------------- wheel controller init ----------------
    rst_n_std = 1'b0;
    sel = 1'b0;
    tick();
    rst_n_whl = 1'b1;
    wait_tx(8'hFF, "whl_tx_ff", n0);
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    ack_cmd(8'hF3, "whl_tx_f3_a");
    ack_cmd(8'hC8, "whl_tx_c8");
    ack_cmd(8'hF3, "whl_tx_f3_b");
    ack_cmd(8'h64, "whl_tx_64");
    ack_cmd(8'hF3, "whl_tx_f3_c");
    ack_cmd(8'h50, "whl_tx_50");
    ack_cmd(8'hF2, "whl_tx_f2");
    send_rx(8'h03);
    ack_cmd(8'hF3, "whl_tx_f3_d");
    ack_cmd(8'h64, "whl_tx_rate");
    ack_cmd(8'hEA, "whl_tx_ea");
    ack_cmd(8'hF4, "whl_tx_f4");
    tick();
    check("whl_init_done", {31'd0, done}, 32'd1);
    check("whl_wheel_mode", {31'd0, wheel}, 32'd1);
    check("whl_init_err", {31'd0, err}, 32'd0);

    // ---------------- 4-byte packet ----------------
    send_rx(8'h08);
    send_rx(8'h05);
    send_rx(8'hFB);
    check("whl_no_pkt_after_3", {31'd0, pv}, 32'd0);
    send_rx(8'h01);
    check("whl_pkt_valid", {31'd0, pv}, 32'd1);
    check("whl_pkt_b1", {24'd0, p1}, 32'h08);
    check("whl_pkt_b2", {24'd0, p2}, 32'h05);
    check("whl_pkt_b3", {24'd0, p3}, 32'hFB);
    check("whl_pkt_b4", {24'd0, p4}, 32'h01);
    send_rx(8'h00);
    check("whl_sync_err_drop", {31'd0, serr}, 32'd1);
    check("whl_drop_no_pkt", {31'd0, pv}, 32'd0);
    check("whl_bytes_held", {24'd0, p4}, 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
